// File: rtl/uni_shift_reg_n.sv
// Parametrised universal shift register with single-step operation and a
// counted burst engine (start/busy/done) for serialiser duty.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | single-step via en, or accept start (burst / one-shot op)
// RUN   | apply latched mode once per edge until remaining count hits 0
module uni_shift_reg_n #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [2:0]       mode,
   input  logic [WIDTH-1:0] i,
   input  logic             sr,
   input  logic             sl,
   input  logic [CNT_W-1:0] cnt,
   input  logic             start,
   output logic [WIDTH-1:0] a,
   output logic             sr_out,
   output logic             sl_out,
   output logic             busy,
   output logic             done
);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [0:0]       state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [CNT_W-1:0] rem_q, rem_d;
   logic [2:0]       mode_lat_q, mode_lat_d;
   logic             done_q, done_d;

   function automatic logic [WIDTH-1:0] shift_op(
      input logic [2:0]       op,
      input logic [WIDTH-1:0] v,
      input logic [WIDTH-1:0] ld,
      input logic             s_r,
      input logic             s_l
   );
      logic [WIDTH-1:0] r;
      r = v;
      case (op)
         3'b001:  r = {s_r, v[WIDTH-1:1]};
         3'b010:  r = {v[WIDTH-2:0], s_l};
         3'b011:  r = ld;
         3'b100:  r = {v[0], v[WIDTH-1:1]};
         3'b101:  r = {v[WIDTH-2:0], v[WIDTH-1]};
         3'b110:  r = {v[WIDTH-1], v[WIDTH-1:1]};
         default: r = v;
      endcase
      return r;
   endfunction

   // Only true shift/rotate modes run as counted bursts; hold/load/reserved
   // complete in a single edge.
   function automatic logic is_burst_mode(input logic [2:0] op);
      logic r;
      case (op)
         3'b001, 3'b010, 3'b100, 3'b101, 3'b110: r = 1'b1;
         default:                                r = 1'b0;
      endcase
      return r;
   endfunction

   always_comb begin
      state_d    = state_q;
      a_d        = a_q;
      rem_d      = rem_q;
      mode_lat_d = mode_lat_q;
      done_d     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               if (is_burst_mode(mode)) begin
                  if (cnt != '0) begin
                     mode_lat_d = mode;
                     rem_d      = cnt;
                     state_d    = ST_RUN;
                  end else begin
                     done_d = 1'b1;
                  end
               end else begin
                  a_d    = shift_op(mode, a_q, i, sr, sl);
                  done_d = 1'b1;
               end
            end else if (en) begin
               a_d = shift_op(mode, a_q, i, sr, sl);
            end
         end
         default: begin
            a_d   = shift_op(mode_lat_q, a_q, i, sr, sl);
            rem_d = rem_q - CNT_ONE;
            if (rem_q == CNT_ONE) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= ST_IDLE;
         a_q        <= '0;
         rem_q      <= '0;
         mode_lat_q <= 3'b000;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         a_q        <= a_d;
         rem_q      <= rem_d;
         mode_lat_q <= mode_lat_d;
         done_q     <= done_d;
      end
   end

   assign a      = a_q;
   assign sr_out = a_q[0];
   assign sl_out = a_q[WIDTH-1];
   assign busy   = (state_q == ST_RUN);
   assign done   = done_q;

endmodule

// File: tb/tb_uni_shift_reg_n.sv
// Bench for uni_shift_reg_n: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against an arithmetic reference model.
module tb_uni_shift_reg_n;

   localparam int W  = 8;
   localparam int CW = 4;
   localparam int MASK = (1 << W) - 1;

   logic          clk;
   logic          rst;
   logic          en;
   logic [2:0]    mode;
   logic [W-1:0]  i;
   logic          sr;
   logic          sl;
   logic [CW-1:0] cnt;
   logic          start;
   logic [W-1:0]  a;
   logic          sr_out;
   logic          sl_out;
   logic          busy;
   logic          done;

   int n_cmp;
   int n_bad;

   int m_a;
   int m_rem;
   int m_mode;
   bit m_busy;
   bit m_done;

   uni_shift_reg_n #(.WIDTH(W), .CNT_W(CW)) dut (
      .clk    (clk),
      .rst    (rst),
      .en     (en),
      .mode   (mode),
      .i      (i),
      .sr     (sr),
      .sl     (sl),
      .cnt    (cnt),
      .start  (start),
      .a      (a),
      .sr_out (sr_out),
      .sl_out (sl_out),
      .busy   (busy),
      .done   (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp_v);
      n_cmp++;
      if (obs != exp_v) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp_v, $time);
      end
   endtask

   function automatic int apply_op(input int op, input int v, input int ld,
                                   input int s_r, input int s_l);
      int msb_w;
      msb_w = 1 << (W - 1);
      case (op)
         1:       return (v / 2) + (s_r * msb_w);
         2:       return ((v * 2) + s_l) & MASK;
         3:       return ld & MASK;
         4:       return (v / 2) + ((v % 2) * msb_w);
         5:       return ((v * 2) & MASK) + ((v >= msb_w) ? 1 : 0);
         6:       return (v / 2) + ((v >= msb_w) ? msb_w : 0);
         default: return v;
      endcase
   endfunction

   function automatic bit is_burst(input int op);
      return (op == 1) || (op == 2) || (op == 4) || (op == 5) || (op == 6);
   endfunction

   task automatic model_reset();
      m_a = 0; m_rem = 0; m_mode = 0; m_busy = 0; m_done = 0;
   endtask

   task automatic model_edge();
      bit nd;
      if (m_busy) begin
         m_a   = apply_op(m_mode, m_a, int'(i), int'(sr), int'(sl));
         m_rem = m_rem - 1;
         m_done = (m_rem == 0);
         if (m_rem == 0) m_busy = 0;
      end else begin
         nd = 0;
         if (start) begin
            if (is_burst(int'(mode))) begin
               if (int'(cnt) > 0) begin
                  m_mode = int'(mode);
                  m_rem  = int'(cnt);
                  m_busy = 1;
               end else begin
                  nd = 1;
               end
            end else begin
               m_a = apply_op(int'(mode), m_a, int'(i), int'(sr), int'(sl));
               nd  = 1;
            end
         end else if (en) begin
            m_a = apply_op(int'(mode), m_a, int'(i), int'(sr), int'(sl));
         end
         m_done = nd;
      end
   endtask

   task automatic check_model();
      chk("m_a",      int'(a),      m_a);
      chk("m_busy",   int'(busy),   int'(m_busy));
      chk("m_done",   int'(done),   int'(m_done));
      chk("m_sr_out", int'(sr_out), m_a % 2);
      chk("m_sl_out", int'(sl_out), (m_a >> (W - 1)) & 1);
   endtask

   // Inputs change at the falling edge, are sampled by DUT and model on the
   // rising edge, and outputs are compared at the following falling edge.
   task automatic drive(input bit e, input int md, input int iv, input bit s_r,
                        input bit s_l, input int c, input bit st);
      en = e; mode = md[2:0]; i = iv[W-1:0]; sr = s_r; sl = s_l;
      cnt = c[CW-1:0]; start = st;
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_model();
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) drive(0, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      int r;
      n_cmp = 0; n_bad = 0;
      rst = 1'b0; en = 0; mode = 0; i = 0; sr = 0; sl = 0; cnt = 0; start = 0;
      model_reset();
      repeat (2) @(negedge clk);
      chk("rst_a", int'(a), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      rst = 1'b1;
      idle(1);

      // reset mid-burst
      drive(1, 3, 'hA5, 0, 0, 0, 0);
      chk("ld_a5", int'(a), 'hA5);
      drive(0, 1, 0, 0, 0, 5, 1);
      drive(0, 0, 0, 0, 0, 0, 0);
      drive(0, 0, 0, 0, 0, 0, 0);
      chk("mid_busy", int'(busy), 1);
      rst = 1'b0;
      #1;
      model_reset();
      chk("arst_a", int'(a), 0);
      chk("arst_busy", int'(busy), 0);
      chk("arst_done", int'(done), 0);
      #1 rst = 1'b1;
      idle(3);
      chk("post_rst_a", int'(a), 0);

      // single-step
      drive(1, 3, 'h96, 0, 0, 0, 0);
      chk("ss_load", int'(a), 'h96);
      chk("ss_slout_pre", int'(sl_out), 1);
      drive(1, 2, 0, 0, 1, 0, 0);
      chk("ss_shl", int'(a), 'h2D);
      drive(1, 6, 0, 1, 0, 0, 0);
      chk("ss_asr", int'(a), 'h16);

      // rotate-left burst with en/mode noise while running
      drive(1, 3, 'h81, 0, 0, 0, 0);
      drive(0, 5, 0, 0, 0, 3, 1);
      chk("rot_busy0", int'(busy), 1);
      drive(1, 3, 'hFF, 0, 0, 0, 1);
      chk("rot_1", int'(a), 'h03);
      chk("rot_busy1", int'(busy), 1);
      drive(1, 1, 'h00, 1, 1, 7, 0);
      chk("rot_2", int'(a), 'h06);
      drive(1, 2, 'h55, 0, 0, 2, 1);
      chk("rot_3", int'(a), 'h0C);
      chk("rot_done", int'(done), 1);
      chk("rot_busy3", int'(busy), 0);
      idle(1);
      chk("rot_done_clr", int'(done), 0);

      // arithmetic burst longer than the register
      drive(1, 3, 'h80, 0, 0, 0, 0);
      drive(0, 6, 0, 0, 0, 9, 1);
      for (int k = 0; k < 9; k++) drive(0, 0, 0, 0, 0, 0, 0);
      chk("asr9_a", int'(a), 'hFF);
      chk("asr9_done", int'(done), 1);
      chk("asr9_busy", int'(busy), 0);

      // zero-count and load-start
      drive(0, 1, 0, 1, 0, 0, 1);
      chk("zc_a", int'(a), 'hFF);
      chk("zc_done", int'(done), 1);
      chk("zc_busy", int'(busy), 0);
      drive(0, 3, 'h3C, 0, 0, 4, 1);
      chk("ldst_a", int'(a), 'h3C);
      chk("ldst_done", int'(done), 1);
      chk("ldst_busy", int'(busy), 0);

      // serial-in burst then back-to-back start in the done cycle
      drive(1, 3, 'h00, 0, 0, 0, 0);
      drive(0, 1, 0, 0, 0, 4, 1);
      drive(0, 0, 0, 1, 0, 0, 0);
      drive(0, 0, 0, 0, 0, 0, 0);
      drive(0, 0, 0, 1, 0, 0, 0);
      drive(0, 0, 0, 1, 0, 0, 0);
      chk("ser_a", int'(a), 'hD0);
      chk("ser_done", int'(done), 1);
      drive(0, 2, 0, 0, 1, 1, 1);
      chk("b2b_busy", int'(busy), 1);
      drive(0, 0, 0, 0, 1, 0, 0);
      chk("b2b_a", int'(a), 'hA1);
      chk("b2b_done", int'(done), 1);

      // randomized traffic
      for (int k = 0; k < 3000; k++) begin
         r = int'($urandom_range(0, 99));
         if (r == 0) begin
            rst = 1'b0;
            #1;
            model_reset();
            check_model();
            #1 rst = 1'b1;
         end
         drive(bit'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
               int'($urandom_range(0, MASK)), bit'($urandom_range(0, 1)),
               bit'($urandom_range(0, 1)),
               ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, (1 << CW) - 1)),
               ($urandom_range(0, 5) == 0));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
